// File: rtl/reg_alu_core_if.sv
// Operand/result bus for reg_alu_core.
// The master drives operands and the opcode; the slave returns the registered result and flags.
interface reg_alu_core_if #(
    parameter int unsigned N = 32
);
    logic         in_valid;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [3:0]   ALUControl;
    logic [N-1:0] RESULT;
    logic [3:0]   flags;
    logic         out_valid;

    modport master (
        output in_valid,
        output A,
        output B,
        output ALUControl,
        input  RESULT,
        input  flags,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  ALUControl,
        output RESULT,
        output flags,
        output out_valid
    );
endinterface

// File: rtl/reg_alu_core.sv
// Single-cycle-latency ALU with registered result and Z/N/C/V flags.
// flags layout: bit3 Z, bit2 N, bit1 C, bit0 V.
module reg_alu_core #(
    parameter int unsigned N = 32
) (
    input logic          clk,
    input logic          rst_n,
    reg_alu_core_if.slave bus
);

    logic [N-1:0] result_q, result_d;
    logic [3:0]   flags_q, flags_d;
    logic         out_valid_q;

    logic [N:0]   sum_ext;
    logic         carry;
    logic         ovf;

    // Decode the opcode into the next result and flag values.
    always_comb begin
        result_d = '0;
        sum_ext  = '0;
        carry    = 1'b0;
        ovf      = 1'b0;
        flags_d  = 4'b0000;
        case (bus.ALUControl)
            4'b0000: begin
                sum_ext  = {1'b0, bus.A} + {1'b0, bus.B};
                result_d = sum_ext[N-1:0];
                carry    = sum_ext[N];
                ovf      = (bus.A[N-1] == bus.B[N-1]) && (result_d[N-1] != bus.A[N-1]);
            end
            4'b0001: begin
                // Carry set means no borrow (A >= B unsigned).
                sum_ext  = {1'b0, bus.A} + {1'b0, ~bus.B} + {{N{1'b0}}, 1'b1};
                result_d = sum_ext[N-1:0];
                carry    = sum_ext[N];
                ovf      = (bus.A[N-1] != bus.B[N-1]) && (result_d[N-1] != bus.A[N-1]);
            end
            4'b0010: result_d = bus.A & bus.B;
            4'b0011: result_d = bus.A | bus.B;
            4'b0100: result_d = bus.A ^ bus.B;
            4'b0101: result_d = ~bus.A;
            4'b0110: begin
                result_d = {bus.A[N-2:0], 1'b0};
                carry    = bus.A[N-1];
                ovf      = bus.A[N-1] ^ bus.A[N-2];
            end
            4'b0111: begin
                result_d = {bus.A[N-1], bus.A[N-1:1]};
                carry    = bus.A[0];
            end
            4'b1000: begin
                result_d = {bus.A[N-2:0], 1'b0};
                carry    = bus.A[N-1];
            end
            4'b1001: begin
                result_d = {1'b0, bus.A[N-1:1]};
                carry    = bus.A[0];
            end
            4'b1010: result_d = bus.A;
            default: result_d = '0;
        endcase
        if (bus.ALUControl > 4'b1010) begin
            flags_d = 4'b1000;
        end else begin
            flags_d = {(result_d == '0), result_d[N-1], carry, ovf};
        end
    end

    // Result/flag registers; reset wins over capture, hold when no valid input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q    <= '0;
            flags_q     <= 4'b0000;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                result_q <= result_d;
                flags_q  <= flags_d;
            end
        end
    end

    assign bus.RESULT    = result_q;
    assign bus.flags     = flags_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_reg_alu_core.sv
// Directed self-checking bench for reg_alu_core (N = 32).
module tb_reg_alu_core;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    reg_alu_core_if #(.N(32)) bus ();

    reg_alu_core #(.N(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the capturing edge.
    task automatic step(input logic rst, input logic vld, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] op);
        rst_n          = rst;
        bus.in_valid   = vld;
        bus.A          = a;
        bus.B          = b;
        bus.ALUControl = op;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] res,
                              input logic [3:0] flg, input logic ov);
        check({tag, ".result"}, bus.RESULT, res);
        check({tag, ".flags"}, {28'd0, bus.flags}, {28'd0, flg});
        check({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, ov});
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        bus.in_valid   = 1'b0;
        bus.A          = '0;
        bus.B          = '0;
        bus.ALUControl = '0;
        @(negedge clk);

        // Reset held two cycles with a valid add presented
        step(1'b0, 1'b1, 32'd5, 32'd3, 4'b0000);
        expect_out("rst1", 32'h0, 4'b0000, 1'b0);
        step(1'b0, 1'b1, 32'd5, 32'd3, 4'b0000);
        expect_out("rst2", 32'h0, 4'b0000, 1'b0);
        // Release with no valid: the op seen during reset must not appear
        step(1'b1, 1'b0, 32'd5, 32'd3, 4'b0000);
        expect_out("rel_idle", 32'h0, 4'b0000, 1'b0);

        // Arithmetic
        step(1'b1, 1'b1, 32'h7FFFFFFF, 32'h1, 4'b0000);
        expect_out("add_ovf", 32'h80000000, 4'b0101, 1'b1);
        step(1'b1, 1'b1, 32'hFFFFFFFF, 32'h1, 4'b0000);
        expect_out("add_carry", 32'h0, 4'b1010, 1'b1);
        step(1'b1, 1'b1, 32'h12345678, 32'h12345678, 4'b0001);
        expect_out("sub_eq", 32'h0, 4'b1010, 1'b1);
        step(1'b1, 1'b1, 32'h0, 32'h1, 4'b0001);
        expect_out("sub_borrow", 32'hFFFFFFFF, 4'b0100, 1'b1);
        step(1'b1, 1'b1, 32'h80000000, 32'h1, 4'b0001);
        expect_out("sub_ovf", 32'h7FFFFFFF, 4'b0011, 1'b1);

        // Logic ops and invalid opcode
        step(1'b1, 1'b1, 32'hF0F0F0F0, 32'h0F0F0F0F, 4'b0010);
        expect_out("and", 32'h0, 4'b1000, 1'b1);
        step(1'b1, 1'b1, 32'hF0F0F0F0, 32'h0F0F0F0F, 4'b1111);
        expect_out("inv_op", 32'h0, 4'b1000, 1'b1);
        step(1'b1, 1'b1, 32'h12340000, 32'h00005678, 4'b0011);
        expect_out("or", 32'h12345678, 4'b0000, 1'b1);
        step(1'b1, 1'b1, 32'hFF00FF00, 32'h0FF00FF0, 4'b0100);
        expect_out("xor", 32'hF0F0F0F0, 4'b0100, 1'b1);
        step(1'b1, 1'b1, 32'h0, 32'h12345678, 4'b0101);
        expect_out("not", 32'hFFFFFFFF, 4'b0100, 1'b1);
        step(1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, 4'b1010);
        expect_out("mov0", 32'h0, 4'b1000, 1'b1);
        step(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1011);
        expect_out("inv_op_b", 32'h0, 4'b1000, 1'b1);

        // Shifts
        step(1'b1, 1'b1, 32'h40000001, 32'h0, 4'b0110);
        expect_out("asl", 32'h80000002, 4'b0101, 1'b1);
        step(1'b1, 1'b1, 32'hC0000000, 32'h0, 4'b0110);
        expect_out("asl_c", 32'h80000000, 4'b0110, 1'b1);
        step(1'b1, 1'b1, 32'h80000001, 32'h0, 4'b1000);
        expect_out("lsl", 32'h00000002, 4'b0010, 1'b1);
        step(1'b1, 1'b1, 32'h80000001, 32'h0, 4'b1001);
        expect_out("lsr", 32'h40000000, 4'b0010, 1'b1);
        step(1'b1, 1'b1, 32'h80000001, 32'h0, 4'b0111);
        expect_out("asr", 32'hC0000000, 4'b0110, 1'b1);

        // Hold for three idle cycles while the inputs change
        step(1'b1, 1'b0, 32'h0, 32'h0, 4'b0000);
        expect_out("hold1", 32'hC0000000, 4'b0110, 1'b0);
        step(1'b1, 1'b0, 32'hFFFFFFFF, 32'h1, 4'b0000);
        expect_out("hold2", 32'hC0000000, 4'b0110, 1'b0);
        step(1'b1, 1'b0, 32'h12345678, 32'h1, 4'b0101);
        expect_out("hold3", 32'hC0000000, 4'b0110, 1'b0);

        // Mid-run reset with a valid op, then an op right at release
        step(1'b0, 1'b1, 32'd5, 32'd3, 4'b0000);
        expect_out("rst_mid", 32'h0, 4'b0000, 1'b0);
        step(1'b1, 1'b1, 32'd2, 32'd2, 4'b0000);
        expect_out("first_after_rst", 32'h4, 4'b0000, 1'b1);
        step(1'b1, 1'b0, 32'd2, 32'd2, 4'b0000);
        expect_out("idle_end", 32'h4, 4'b0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
